// File: rtl/minisys_io_pkg.sv
// Shared Minisys IO definitions: timer register offsets, mode/status bit
// positions and the stored mode payload.
package minisys_io_pkg;

   localparam int unsigned IO_ADDR_W = 3;
   localparam int unsigned STAT_W    = 16;

   // Write-side offsets
   localparam logic [IO_ADDR_W-1:0] TMR_MODE0 = 3'h0;
   localparam logic [IO_ADDR_W-1:0] TMR_MODE1 = 3'h2;
   localparam logic [IO_ADDR_W-1:0] TMR_INIT0 = 3'h4;
   localparam logic [IO_ADDR_W-1:0] TMR_INIT1 = 3'h6;

   // Read-side aliases of the same offsets
   localparam logic [IO_ADDR_W-1:0] TMR_STAT0 = TMR_MODE0;
   localparam logic [IO_ADDR_W-1:0] TMR_STAT1 = TMR_MODE1;
   localparam logic [IO_ADDR_W-1:0] TMR_CUR0  = TMR_INIT0;
   localparam logic [IO_ADDR_W-1:0] TMR_CUR1  = TMR_INIT1;

   localparam int unsigned MODE_SRC  = 0;
   localparam int unsigned MODE_RPT  = 1;
   localparam int unsigned STAT_DONE = 15;
   localparam int unsigned STAT_RUN  = 0;

   typedef struct packed {
      logic rpt;
      logic src;
   } tmr_mode_t;

   function automatic logic [STAT_W-1:0] stat_word(input logic done, input logic running);
      logic [STAT_W-1:0] w;
      w            = '0;
      w[STAT_DONE] = done;
      w[STAT_RUN]  = running;
      return w;
   endfunction

endpackage

// File: rtl/minisys_timer_ch.sv
// One down-counting timer channel: pulse synchronizer, edge detect,
// mode/init/cur/running/done state and the registered active-low cout.
module minisys_timer_ch
   import minisys_io_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode_we,
   input  logic             init_we,
   input  logic             stat_rd,
   input  logic [CNT_W-1:0] wdata,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] cur,
   output logic             running,
   output logic             done,
   output logic             cout
);

   localparam int unsigned SYNC_W = 3;

   logic [SYNC_W-1:0] sync_q;
   tmr_mode_t         mode_q, mode_nx;
   logic [CNT_W-1:0]  init_q, init_nx;
   logic [CNT_W-1:0]  cur_nx;
   logic              run_nx, done_nx;
   logic              edge_c, dec_c, tc_c;

   // sync_q[1:0] is the synchronizer, sync_q[2] holds the previous value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= {sync_q[1:0], pulse_in};
   end

   // A CPU write in the same cycle as terminal count takes precedence
   always_comb begin
      edge_c = sync_q[1] & ~sync_q[2];
      dec_c  = running & (mode_q.src ? edge_c : 1'b1);
      tc_c   = dec_c & (cur == CNT_W'(1)) & ~init_we & ~mode_we;
   end

   always_comb begin
      mode_nx = mode_q;
      init_nx = init_q;
      cur_nx  = cur;
      run_nx  = running;
      done_nx = done;
      if (stat_rd) done_nx = 1'b0;
      if (mode_we) begin
         mode_nx = '{rpt: wdata[MODE_RPT], src: wdata[MODE_SRC]};
         run_nx  = 1'b0;
         done_nx = 1'b0;
      end else if (init_we) begin
         init_nx = wdata;
         cur_nx  = wdata;
         run_nx  = |wdata;
      end else if (dec_c) begin
         if (tc_c) begin
            done_nx = 1'b1;
            if (mode_q.rpt) begin
               cur_nx = init_q;
            end else begin
               cur_nx = '0;
               run_nx = 1'b0;
            end
         end else begin
            cur_nx = cur - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q  <= '0;
         init_q  <= '0;
         cur     <= '0;
         running <= 1'b0;
         done    <= 1'b0;
         cout    <= 1'b1;
      end else begin
         mode_q  <= mode_nx;
         init_q  <= init_nx;
         cur     <= cur_nx;
         running <= run_nx;
         done    <= done_nx;
         cout    <= ~tc_c;
      end
   end

endmodule

// File: rtl/minisys_timer.sv
// Minisys two-channel memory-mapped timer/counter: address decode and
// combinational read mux. Channel 1 exists only with MINISYS_TIMER_CH1_EN.
module minisys_timer
   import minisys_io_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cs,
   input  logic                 iowrite,
   input  logic                 ioread,
   input  logic [IO_ADDR_W-1:0] addr,
   input  logic [CNT_W-1:0]     wdata,
   output logic [CNT_W-1:0]     rdata,
   input  logic                 pulse_in0,
   input  logic                 pulse_in1,
   output logic                 cout0,
   output logic                 cout1
);

   logic [IO_ADDR_W-1:0] word_addr;
   logic                 wr_c, rd_c;
   logic [CNT_W-1:0]     cur0, cur1;
   logic                 run0, run1, done0, done1;
   logic                 unused_addr;

   // Byte offsets are halfword-aligned; bit 0 is ignored
   assign word_addr   = {addr[IO_ADDR_W-1:1], 1'b0};
   assign unused_addr = addr[0];
   assign wr_c        = cs & iowrite;
   assign rd_c        = cs & ioread;

   minisys_timer_ch #(.CNT_W(CNT_W)) u_ch0 (
      .clk      (clk),
      .rst      (rst),
      .mode_we  (wr_c && word_addr == TMR_MODE0),
      .init_we  (wr_c && word_addr == TMR_INIT0),
      .stat_rd  (rd_c && word_addr == TMR_STAT0),
      .wdata    (wdata),
      .pulse_in (pulse_in0),
      .cur      (cur0),
      .running  (run0),
      .done     (done0),
      .cout     (cout0)
   );

`ifdef MINISYS_TIMER_CH1_EN
   minisys_timer_ch #(.CNT_W(CNT_W)) u_ch1 (
      .clk      (clk),
      .rst      (rst),
      .mode_we  (wr_c && word_addr == TMR_MODE1),
      .init_we  (wr_c && word_addr == TMR_INIT1),
      .stat_rd  (rd_c && word_addr == TMR_STAT1),
      .wdata    (wdata),
      .pulse_in (pulse_in1),
      .cur      (cur1),
      .running  (run1),
      .done     (done1),
      .cout     (cout1)
   );
`else
   logic unused_ch1;
   assign unused_ch1 = pulse_in1;
   assign cur1       = '0;
   assign run1       = 1'b0;
   assign done1      = 1'b0;
   assign cout1      = 1'b1;
`endif

   // Reads are combinational so the single-cycle CPU sees data in the same cycle
   always_comb begin
      rdata = '0;
      if (rd_c) begin
         case (word_addr)
            TMR_STAT0: rdata = CNT_W'(stat_word(done0, run0));
            TMR_STAT1: rdata = CNT_W'(stat_word(done1, run1));
            TMR_CUR0:  rdata = cur0;
            TMR_CUR1:  rdata = cur1;
            default:   rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_minisys_timer.sv
// Directed self-checking bench for minisys_timer; the counter-mode test runs
// on channel 1 when MINISYS_TIMER_CH1_EN is defined, otherwise on channel 0.
module tb_minisys_timer;

   logic        clk, rst, cs, iowrite, ioread;
   logic [2:0]  addr;
   logic [15:0] wdata, rdata;
   logic        pulse_in0, pulse_in1, cout0, cout1;
   logic        cpulse;
   logic        cnt_cout;
   logic [15:0] d;
   int          n_checks, n_err, lows;

`ifdef MINISYS_TIMER_CH1_EN
   localparam logic [2:0] CM = 3'h2, CI = 3'h6;
   assign pulse_in0 = 1'b0;
   assign pulse_in1 = cpulse;
   assign cnt_cout  = cout1;
`else
   localparam logic [2:0] CM = 3'h0, CI = 3'h4;
   assign pulse_in0 = cpulse;
   assign pulse_in1 = 1'b0;
   assign cnt_cout  = cout0;
`endif

   minisys_timer dut (
      .clk(clk), .rst(rst), .cs(cs), .iowrite(iowrite), .ioread(ioread),
      .addr(addr), .wdata(wdata), .rdata(rdata),
      .pulse_in0(pulse_in0), .pulse_in1(pulse_in1),
      .cout0(cout0), .cout1(cout1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Write whose effective edge is the one after the next negedge
   task automatic wr(input logic [2:0] a, input logic [15:0] v);
      @(negedge clk);
      cs = 1'b1; iowrite = 1'b1; addr = a; wdata = v;
      @(negedge clk);
      cs = 1'b0; iowrite = 1'b0; wdata = '0;
   endtask

   // Full read cycle, spanning a rising edge (clears done on status reads)
   task automatic rd(input logic [2:0] a, output logic [15:0] v);
      @(negedge clk);
      cs = 1'b1; ioread = 1'b1; addr = a;
      #1 v = rdata;
      @(negedge clk);
      cs = 1'b0; ioread = 1'b0;
   endtask

   // Combinational look that is released before any rising edge
   task automatic peek(input logic [2:0] a, output logic [15:0] v);
      cs = 1'b1; ioread = 1'b1; addr = a;
      #1 v = rdata;
      cs = 1'b0; ioread = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_err = 0;
      rst = 1'b0; cs = 1'b0; iowrite = 1'b0; ioread = 1'b0;
      addr = '0; wdata = '0; cpulse = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         peek(3'(2 * i), d);
         check($sformatf("reset_rdata_%0d", 2 * i), d, 16'h0000);
      end
      check("reset_cout0", 16'(cout0), 16'h0001);
      check("reset_cout1", 16'(cout1), 16'h0001);
      cs = 1'b0; ioread = 1'b1; addr = 3'h4;
      #1 check("rdata_no_cs", rdata, 16'h0000);
      ioread = 1'b0;

      // One-shot timer, init 5: cout low after the 5th edge following the write edge
      wr(3'h0, 16'h0000);
      wr(3'h4, 16'h0005);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         check($sformatf("oneshot_cout_%0d", i), 16'(cout0), (i == 5) ? 16'h0000 : 16'h0001);
      end
      rd(3'h0, d);
      check("oneshot_stat_done", d, 16'h8000);
      rd(3'h0, d);
      check("oneshot_stat_cleared", d, 16'h0000);

      // Repeat timer, init 3: cur 3,2,1,3,... with cout low on each reload
      wr(3'h0, 16'h0002);
      wr(3'h4, 16'h0003);
      for (int i = 0; i <= 6; i++) begin
         peek(3'h4, d);
         check($sformatf("repeat_cur_%0d", i), d, 16'(3 - (i % 3)));
         check($sformatf("repeat_cout_%0d", i), 16'(cout0),
               (i > 0 && i % 3 == 0) ? 16'h0000 : 16'h0001);
         if (i < 6) @(negedge clk);
      end
      peek(3'h5, d);
      check("odd_addr_alias", d, 16'h0003);
      wr(3'h0, 16'h0000);

      // Init 0 leaves running clear
      wr(3'h4, 16'h0000);
      peek(3'h0, d);
      check("init0_stat", d, 16'h0000);
      repeat (2) @(negedge clk);
      check("init0_cout", 16'(cout0), 16'h0001);

      // Init write on the terminal-count edge: reload, no pulse
      wr(3'h4, 16'h0003);
      @(negedge clk);
      wr(3'h4, 16'h0007);
      check("init_on_tc_cout", 16'(cout0), 16'h0001);
      peek(3'h4, d);
      check("init_on_tc_cur", d, 16'h0007);
      peek(3'h0, d);
      check("init_on_tc_stat", d, 16'h0001);
      wr(3'h0, 16'h0000);

      // Status read on the terminal-count edge: done survives
      wr(3'h4, 16'h0003);
      @(negedge clk);
      rd(3'h0, d);
      check("rd_on_tc_data", d, 16'h0001);
      check("rd_on_tc_cout", 16'(cout0), 16'h0000);
      peek(3'h0, d);
      check("rd_on_tc_done_kept", d, 16'h8000);
      wr(3'h0, 16'h0000);

      // Counter mode, init 2, two external pulses
      wr(CM, 16'h0001);
      wr(CI, 16'h0002);
      cpulse = 1'b1;
      @(negedge clk); peek(CI, d); check("cnt_cur_hold1", d, 16'h0002);
      @(negedge clk); peek(CI, d); check("cnt_cur_hold2", d, 16'h0002);
      cpulse = 1'b0;
      @(negedge clk); peek(CI, d); check("cnt_cur_dec", d, 16'h0001);
      @(negedge clk);
      cpulse = 1'b1;
      @(negedge clk); check("cnt_cout_a", 16'(cnt_cout), 16'h0001);
      @(negedge clk); check("cnt_cout_b", 16'(cnt_cout), 16'h0001);
      cpulse = 1'b0;
      @(negedge clk); check("cnt_cout_tc", 16'(cnt_cout), 16'h0000);
      peek(CI, d); check("cnt_cur_zero", d, 16'h0000);
      @(negedge clk); check("cnt_cout_after", 16'(cnt_cout), 16'h0001);
      rd(CM, d);
      check("cnt_stat_done", d, 16'h8000);
      wr(CM, 16'h0000);

`ifndef MINISYS_TIMER_CH1_EN
      // Channel 1 absent: its offsets ignore writes and read 0
      wr(3'h2, 16'h0000);
      wr(3'h6, 16'h0005);
      peek(3'h6, d);
      check("ch1_off_cur", d, 16'h0000);
      peek(3'h2, d);
      check("ch1_off_stat", d, 16'h0000);
`endif

      // Reset mid-count aborts with no pulse
      wr(3'h0, 16'h0000);
      wr(3'h4, 16'd100);
      repeat (50) @(negedge clk);
      peek(3'h4, d);
      check("midrst_cur50", d, 16'd50);
      #2 rst = 1'b0;
      peek(3'h4, d);
      check("midrst_cur_zero", d, 16'h0000);
      peek(3'h0, d);
      check("midrst_stat_zero", d, 16'h0000);
      check("midrst_cout", 16'(cout0), 16'h0001);
      lows = 0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 110; i++) begin
         @(negedge clk);
         if (cout0 !== 1'b1) lows++;
      end
      check("midrst_no_pulse", 16'(lows), 16'h0000);
      peek(3'h4, d);
      check("midrst_cur_after", d, 16'h0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
